// File: rtl/pic_pkg.sv
// Shared types for the 8-line PIC priority sequencer.
// FSM state encoding, IR width and one-hot helper.
package pic_pkg;

  localparam int NUM_IR = 8;
  localparam int IRW    = 3;

  typedef logic [IRW-1:0] ir_idx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_ACK1
  } pic_state_t;

  function automatic logic [NUM_IR-1:0] ir_bit(
    input ir_idx_t i_idx
  );
    logic [NUM_IR-1:0] v;
    v        = '0;
    v[i_idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating find-first: highest-priority set bit counted from i_base.
// o_rank is the distance from the base (0 = highest priority).
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] i_req,
  input  ir_idx_t           i_base,
  output logic              o_valid,
  output ir_idx_t           o_idx,
  output ir_idx_t           o_rank
);

  ir_idx_t w_pos;

  // Scan lowest priority first so the last hit is the winner.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    o_rank  = '0;
    w_pos   = '0;
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      w_pos = i_base + IRW'(k);
      if (i_req[w_pos]) begin
        o_valid = 1'b1;
        o_idx   = w_pos;
        o_rank  = IRW'(k);
      end
    end
  end

endmodule

// File: rtl/pic_priority_sequencer.sv
// 8259-style request/in-service tracking and two-pulse INTA sequencer.
// Supports edge/level triggering, AEOI, EOI and rotating priority.
module pic_priority_sequencer #(
  parameter int NUM_IR = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] ir_in,
  input  logic [NUM_IR-1:0] imr,
  input  logic              level_mode,
  input  logic              aeoi,
  input  logic              rotate_en,
  input  logic              eoi_ns,
  input  logic              eoi_sp,
  input  logic [2:0]        eoi_level,
  input  logic              inta_pulse,
  output logic              int_out,
  output logic [2:0]        ir_num,
  output logic              ack_done,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr
);

  import pic_pkg::*;

  logic [NUM_IR-1:0] r_ir_hist;
  logic [NUM_IR-1:0] r_irr;
  logic [NUM_IR-1:0] r_isr;
  ir_idx_t           r_base;
  ir_idx_t           r_win;
  ir_idx_t           r_ir_num;
  logic              r_spur;
  logic              r_ack_done;
  pic_state_t        r_state;

  logic [NUM_IR-1:0] w_cand;
  logic [NUM_IR-1:0] w_edge;
  logic [NUM_IR-1:0] w_irr_clr;
  logic [NUM_IR-1:0] w_isr_set;
  logic [NUM_IR-1:0] w_aeoi_clr;
  logic [NUM_IR-1:0] w_sp_clr;
  logic [NUM_IR-1:0] w_ns_clr;
  logic [NUM_IR-1:0] w_isr_clr;
  logic              w_c_vld;
  logic              w_s_vld;
  ir_idx_t           w_c_idx;
  ir_idx_t           w_c_rank;
  ir_idx_t           w_s_idx;
  ir_idx_t           w_s_rank;
  logic              w_qual;
  logic              w_first;
  logic              w_second;
  ir_idx_t           w_base_nxt;

  assign w_cand = r_irr & ~imr;
  assign w_edge = ir_in & ~r_ir_hist;

  pic_priority_resolver u_irr_res (
    .i_req   (w_cand),
    .i_base  (r_base),
    .o_valid (w_c_vld),
    .o_idx   (w_c_idx),
    .o_rank  (w_c_rank)
  );

  pic_priority_resolver u_isr_res (
    .i_req   (r_isr),
    .i_base  (r_base),
    .o_valid (w_s_vld),
    .o_idx   (w_s_idx),
    .o_rank  (w_s_rank)
  );

  assign w_qual = w_c_vld &&
                  (!w_s_vld || (w_c_rank < w_s_rank));

  assign w_first  = (r_state == S_PEND) && inta_pulse;
  assign w_second = (r_state == S_ACK1) && inta_pulse;

  always_comb begin
    w_irr_clr  = '0;
    w_isr_set  = '0;
    w_aeoi_clr = '0;
    w_sp_clr   = '0;
    w_ns_clr   = '0;
    if (w_first && w_c_vld) begin
      w_isr_set = ir_bit(w_c_idx);
      if (!level_mode)
        w_irr_clr = ir_bit(w_c_idx);
    end
    if (w_second && aeoi && !r_spur)
      w_aeoi_clr = ir_bit(r_win) & r_isr;
    if (eoi_sp)
      w_sp_clr = ir_bit(eoi_level) & r_isr;
    if (eoi_ns && w_s_vld)
      w_ns_clr = ir_bit(w_s_idx);
    w_isr_clr = w_aeoi_clr | w_sp_clr | w_ns_clr;
  end

  always_comb begin
    w_base_nxt = r_base;
    if (rotate_en) begin
      if (|w_aeoi_clr)
        w_base_nxt = r_win + 3'd1;
      else if (|w_sp_clr)
        w_base_nxt = eoi_level + 3'd1;
      else if (|w_ns_clr)
        w_base_nxt = w_s_idx + 3'd1;
    end
  end

  // A fresh request edge wins over the acknowledge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir_hist <= '0;
      r_irr     <= '0;
      r_isr     <= '0;
      r_base    <= '0;
    end else begin
      r_ir_hist <= ir_in;
      if (level_mode)
        r_irr <= ir_in;
      else
        r_irr <= (r_irr & ~w_irr_clr) | w_edge;
      r_isr  <= (r_isr & ~w_isr_clr) | w_isr_set;
      r_base <= w_base_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_win      <= '0;
      r_spur     <= 1'b0;
      r_ir_num   <= '0;
      r_ack_done <= 1'b0;
    end else begin
      r_ack_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_qual)
            r_state <= S_PEND;
        end
        S_PEND: begin
          if (inta_pulse) begin
            r_state <= S_ACK1;
            r_win   <= w_c_vld ? w_c_idx : 3'd7;
            r_spur  <= !w_c_vld;
          end else if (!w_qual) begin
            r_state <= S_IDLE;
          end
        end
        S_ACK1: begin
          if (inta_pulse) begin
            r_state    <= S_IDLE;
            r_ack_done <= 1'b1;
            r_ir_num   <= r_win;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign int_out  = (r_state == S_PEND) && w_qual;
  assign ir_num   = r_ir_num;
  assign ack_done = r_ack_done;
  assign irr      = r_irr;
  assign isr      = r_isr;

endmodule

// File: tb/tb_pic_priority_sequencer.sv
// Scoreboard bench for pic_priority_sequencer.
// Expected acks are queued on the second INTA, checked on ack_done.
module tb_pic_priority_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] ir_in;
  logic [7:0] imr;
  logic       level_mode;
  logic       aeoi;
  logic       rotate_en;
  logic       eoi_ns;
  logic       eoi_sp;
  logic [2:0] eoi_level;
  logic       inta_pulse;
  logic       int_out;
  logic [2:0] ir_num;
  logic       ack_done;
  logic [7:0] irr;
  logic [7:0] isr;

  typedef struct {
    logic [2:0] num;
    logic [7:0] isr;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  pic_priority_sequencer #(.NUM_IR(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir_in      (ir_in),
    .imr        (imr),
    .level_mode (level_mode),
    .aeoi       (aeoi),
    .rotate_en  (rotate_en),
    .eoi_ns     (eoi_ns),
    .eoi_sp     (eoi_sp),
    .eoi_level  (eoi_level),
    .inta_pulse (inta_pulse),
    .int_out    (int_out),
    .ir_num     (ir_num),
    .ack_done   (ack_done),
    .irr        (irr),
    .isr        (isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack_done) begin
      if (sb.size() == 0) begin
        chk("ack_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_num", 32'(ir_num), 32'(e.num));
        chk("ack_isr", 32'(isr), 32'(e.isr));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic raise(input logic [7:0] v);
    ir_in = v;
    tick();
    ir_in = 8'h00;
  endtask

  task automatic wait_int();
    int n;
    n = 0;
    while (!int_out && n < 20) begin
      tick();
      n++;
    end
    if (!int_out)
      chk("int_timeout", 32'd0, 32'd1);
  endtask

  task automatic inta();
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
  endtask

  task automatic do_eoi_ns();
    eoi_ns = 1'b1;
    tick();
    eoi_ns = 1'b0;
  endtask

  task automatic do_eoi_sp(input logic [2:0] lvl);
    eoi_sp    = 1'b1;
    eoi_level = lvl;
    tick();
    eoi_sp = 1'b0;
  endtask

  task automatic ack_seq(input logic [2:0] num,
                         input logic [7:0] isr_exp);
    wait_int();
    inta();
    chk("int_in_ack1", 32'(int_out), 32'd0);
    tick();
    sb.push_back('{num: num, isr: isr_exp});
    inta();
    tick();
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    ir_in      = '0;
    imr        = '0;
    level_mode = 1'b0;
    aeoi       = 1'b0;
    rotate_en  = 1'b0;
    eoi_ns     = 1'b0;
    eoi_sp     = 1'b0;
    eoi_level  = '0;
    inta_pulse = 1'b0;
    #2;
    chk("rst_irr", 32'(irr), 32'h0);
    chk("rst_isr", 32'(isr), 32'h0);
    chk("rst_int", 32'(int_out), 32'd0);
    chk("rst_ack", 32'(ack_done), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick();

    // single edge request on IR3
    raise(8'h08);
    wait_int();
    chk("ir3_int", 32'(int_out), 32'd1);
    ack_seq(3'd3, 8'h08);
    chk("ir3_isr", 32'(isr), 32'h08);
    chk("ir3_irr", 32'(irr), 32'h00);
    do_eoi_ns();
    chk("ir3_eoi", 32'(isr), 32'h00);

    // IR3 and IR5 together, fixed priority
    raise(8'h28);
    ack_seq(3'd3, 8'h08);
    chk("pair_irr", 32'(irr), 32'h20);
    tick(2);
    chk("pair_blocked", 32'(int_out), 32'd0);
    do_eoi_ns();
    chk("pair_eoi", 32'(isr), 32'h00);
    ack_seq(3'd5, 8'h20);
    do_eoi_ns();
    chk("pair_eoi2", 32'(isr), 32'h00);

    // rotation: base moves to k+1 on each EOI
    rotate_en = 1'b1;
    raise(8'h04);
    ack_seq(3'd2, 8'h04);
    do_eoi_ns();
    raise(8'h05);
    ack_seq(3'd0, 8'h01);
    chk("rot_irr", 32'(irr), 32'h04);
    do_eoi_ns();
    ack_seq(3'd2, 8'h04);
    do_eoi_ns();
    raise(8'h14);
    ack_seq(3'd4, 8'h10);
    do_eoi_ns();
    ack_seq(3'd2, 8'h04);
    do_eoi_ns();
    rotate_en = 1'b0;
    chk("rot_isr", 32'(isr), 32'h00);

    // specific EOI, including a no-op target
    raise(8'h02);
    ack_seq(3'd1, 8'h02);
    do_eoi_sp(3'd5);
    chk("sp_noop", 32'(isr), 32'h02);
    do_eoi_sp(3'd1);
    chk("sp_clear", 32'(isr), 32'h00);

    // masked request is ignored until unmasked
    imr = 8'h80;
    raise(8'h80);
    tick(3);
    chk("mask_int", 32'(int_out), 32'd0);
    imr = 8'h00;
    ack_seq(3'd7, 8'h80);
    do_eoi_ns();

    // level mode, request withdrawn -> spurious IR7
    level_mode = 1'b1;
    ir_in = 8'h10;
    wait_int();
    ir_in = 8'h00;
    tick();
    chk("lvl_drop_int", 32'(int_out), 32'd0);
    inta();
    chk("spur_isr", 32'(isr), 32'h00);
    tick();
    sb.push_back('{num: 3'd7, isr: 8'h00});
    inta();
    tick();
    level_mode = 1'b0;
    tick(2);

    // automatic EOI
    aeoi = 1'b1;
    raise(8'h40);
    ack_seq(3'd6, 8'h00);
    chk("aeoi_isr", 32'(isr), 32'h00);
    aeoi = 1'b0;

    // reset between the two INTA strobes
    raise(8'h01);
    wait_int();
    inta();
    chk("mid_isr", 32'(isr), 32'h01);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_irr", 32'(irr), 32'h00);
    chk("mr_isr", 32'(isr), 32'h00);
    chk("mr_num", 32'(ir_num), 32'h0);
    chk("mr_ack", 32'(ack_done), 32'd0);
    chk("mr_int", 32'(int_out), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick();
    inta();
    tick(3);
    chk("post_int", 32'(int_out), 32'd0);
    chk("post_isr", 32'(isr), 32'h00);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
